// File: rtl/shift_seq_ctrl.sv
// Serial loader for an external shift register: shifts a word MSB first, then holds it for a consumer.
// Define SHIFT_SEQ_CHECK_EN to add the CHECK state that compares the register readback against the word.
module shift_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_d,
  output logic             sr_shift,
  input  logic [WIDTH-1:0] sr_bits,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef SHIFT_SEQ_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2, HOLD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd3} state_t;
`endif

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_err_reg, out_err_next;
  logic [WIDTH-1:0] word_rev;

  // Bit-reversed copy lets the counter index the word MSB first directly.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign word_rev[gi] = word_reg[WIDTH-1-gi];
  end

`ifndef SHIFT_SEQ_CHECK_EN
  logic unused_sr_bits;
  assign unused_sr_bits = ^sr_bits;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      word_reg     <= '0;
      out_data_reg <= '0;
      out_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      word_reg     <= word_next;
      out_data_reg <= out_data_next;
      out_err_reg  <= out_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    word_next     = word_reg;
    out_data_next = out_data_reg;
    out_err_next  = out_err_reg;
    in_ready      = 1'b0;
    sr_shift      = 1'b0;
    sr_d          = 1'b0;
    out_valid     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_next    = in_data;
          cnt_next     = '0;
          out_err_next = 1'b0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        sr_shift = 1'b1;
        sr_d     = word_rev[cnt_reg];
        // Counter parks on the last index rather than wrapping.
        if (cnt_reg == CW'(WIDTH - 1)) begin
`ifdef SHIFT_SEQ_CHECK_EN
          state_next = CHECK;
`else
          out_data_next = word_reg;
          state_next    = HOLD;
`endif
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef SHIFT_SEQ_CHECK_EN
      CHECK: begin
        out_data_next = sr_bits;
        out_err_next  = (sr_bits != word_reg);
        state_next    = HOLD;
      end
`endif
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_data = out_data_reg;
  assign out_err  = out_err_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl with a behavioural external shift register.
module tb_shift_seq_ctrl;
  localparam int W = 4;
`ifdef SHIFT_SEQ_CHECK_EN
  localparam int LAT = W + 1;
  localparam bit CHK = 1'b1;
`else
  localparam int LAT = W;
  localparam bit CHK = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sr_d;
  logic         sr_shift;
  logic [W-1:0] sr_bits;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_err;
  logic         busy;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sr_d(sr_d), .sr_shift(sr_shift), .sr_bits(sr_bits), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // External shift register; corrupt forces bit 2 low on the readback.
  logic [W-1:0] sr_model = '0;
  logic         corrupt = 1'b0;
  always @(posedge CLK) if (sr_shift) sr_model <= {sr_model[W-2:0], sr_d};
  assign sr_bits = corrupt ? (sr_model & 4'b1011) : sr_model;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           rise;
  } exp_t;

  exp_t sb[$];
  bit   sd_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, when inputs and outputs are settled.
  bit   vprev = 1'b0;
  int   run = 0;
  exp_t tmp;
  always @(negedge CLK) begin
    #1;
    if (mon_en) begin
      chk("busy_vs_in_ready", busy, !in_ready);
      if (sr_shift) begin
        run++;
        chk("shift_run_le_width", run <= W, 1);
        if (sd_q.size() == 0) chk("sr_d_unexpected_shift", 1, 0);
        else chk("sr_d_bit", sr_d, sd_q.pop_front());
      end else begin
        run = 0;
        chk("sr_d_idle_zero", sr_d, 0);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("out_valid_unexpected", out_valid, 0);
        end else begin
          if (!vprev) chk("out_valid_rise_cycle", cyc, sb[0].rise);
          chk("out_data", out_data, sb[0].data);
          chk("out_err", out_err, sb[0].err);
          if (out_ready) tmp = sb.pop_front();
          $display("[TB] cycle %0d out_data=%b out_err=%b out_ready=%b", cyc, out_data, out_err, out_ready);
        end
      end
      vprev = out_valid && !out_ready;
    end
  end

  // Called just after a falling edge; returns the handshake edge number.
  task automatic send(input logic [W-1:0] w, input logic [W-1:0] exp_data, input logic exp_err,
                      output int e0);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_data  = w;
    in_valid = 1'b1;
    e0 = cyc + 1;
    e.data = exp_data;
    e.err  = exp_err;
    e.rise = e0 + LAT;
    sb.push_back(e);
    for (int i = W - 1; i >= 0; i--) sd_q.push_back(w[i]);
    $display("[TB] cycle %0d send %b", e0, w);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_sr_shift"}, sr_shift, 0);
    chk({tag, "_sr_d"}, sr_d, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int e0a, e0b, n;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals("reset");
    mon_en = 1'b1;

    // Basic word
    send(4'b1011, 4'b1011, 1'b0, e0a);
    wait_drain();

    // Corrupted readback
    corrupt = 1'b1;
    send(4'b0110, CHK ? 4'b0010 : 4'b0110, CHK, e0a);
    wait_drain();
    corrupt = 1'b0;

    // Consumer stall in HOLD with ignored input pulses
    out_ready = 1'b0;
    send(4'b0101, 4'b0101, 1'b0, e0a);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("hold_reached", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_in_ready_low", in_ready, 0);
      in_data  = 4'b1111;
      in_valid = (i == 2 || i == 5);
      @(negedge CLK);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("after_hold_in_ready", in_ready, 1);
    chk("after_hold_out_valid", out_valid, 0);
    wait_drain();

    // Reset during the second shift cycle
    in_data  = 4'b1111;
    in_valid = 1'b1;
    sd_q.push_back(1'b1);
    sd_q.push_back(1'b1);
    $display("[TB] cycle %0d send 1111 (to be reset)", cyc + 1);
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_reset_vals("midreset");
    chk("midreset_sd_consumed", sd_q.size(), 0);
    repeat (6) @(negedge CLK);
    send(4'b0001, 4'b0001, 1'b0, e0a);
    wait_drain();

    // Back-to-back words with a consumer always ready
    send(4'b1000, 4'b1000, 1'b0, e0a);
    send(4'b0111, 4'b0111, 1'b0, e0b);
    chk("b2b_handshake_gap", e0b, e0a + LAT + 2);
    wait_drain();

    send(4'b1100, 4'b1100, 1'b0, e0a);
    wait_drain();
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, shift-register length in bits; legal range 2..16.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  WIDTH  parallel word to load into the shift register.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  controller can accept a word.
REQ-007 sr_d  output  1  serial data driven to the shift register D input.
REQ-008 sr_shift  output  1  shift strobe; the register shifts on edges where this is high.
REQ-009 sr_bits  input  WIDTH  parallel readback of the shift register (bit 0 nearest D).
REQ-010 out_data  output  WIDTH  word delivered after loading.
REQ-011 out_valid  output  1  out_data and out_err are valid.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 out_err  output  1  readback mismatch flag for the current word.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL use the states IDLE, SHIFT, CHECK and HOLD.
REQ-016 IDLE: in_ready=1; on in_valid=1, latch in_data, clear the bit counter, go to SHIFT; in_valid=0 stays IDLE.
REQ-017 in_ready SHALL be 0 in SHIFT, CHECK and HOLD; in_valid there is ignored and no data is latched.
REQ-018 SHIFT: sr_shift=1 for exactly WIDTH consecutive cycles; in the cycle with counter value n, sr_d=word[WIDTH-1-n] (MSB first), so sr_bits equals the latched word after the last shift edge.
REQ-019 The counter SHALL be ceil(log2(WIDTH)) bits wide; on the final SHIFT cycle (n=WIDTH-1) it does not wrap, and the FSM leaves SHIFT.
REQ-020 sr_shift=0 and sr_d=0 in every state other than SHIFT.
REQ-021 CHECK: one cycle; register out_data<=sr_bits and out_err<=(sr_bits!=latched word); go to HOLD.
REQ-022 HOLD: out_valid=1; out_data and out_err are held stable until out_ready=1.
REQ-023 HOLD with out_ready=1: the transfer completes and the FSM returns to IDLE; in_ready rises the following cycle (no same-cycle bypass).
REQ-024 Latency, with the check enabled: handshake at edge E0, then sr_shift high during cycles E0+1..E0+WIDTH, and out_valid high from edge E0+WIDTH+1.
REQ-025 out_err SHALL be cleared on every accepted input word.

Reset
REQ-026 RST=1 at an edge SHALL force IDLE from any state, including mid-SHIFT, and takes priority over all other inputs.
REQ-027 After reset: in_ready=1, out_valid=0, out_data=0, out_err=0, sr_shift=0, sr_d=0, busy=0, counter=0, latched word=0.
REQ-028 A word interrupted by reset SHALL be discarded; no out_valid is produced for it.

Configuration
REQ-029 Macro SHIFT_SEQ_CHECK_EN defined: the CHECK state and readback comparison are compiled in as specified above.
REQ-030 SHIFT_SEQ_CHECK_EN undefined: the CHECK state is removed and the last SHIFT cycle goes directly to HOLD; out_data<=latched word, out_err is tied 0, sr_bits is unused, and out_valid rises at edge E0+WIDTH.

Verification
REQ-031 Reset, then in_data=4'b1011 with in_valid pulsed one cycle -> sr_d sequence 1,0,1,1 with sr_shift high 4 cycles; out_data=4'b1011; out_err=0; out_valid at E0+5 (check on).
REQ-032 Model register corrupted (bit 2 forced 0) while loading 4'b0110 -> out_data=4'b0010, out_err=1.
REQ-033 Hold out_ready=0 for 10 cycles in HOLD -> out_valid and out_data stable; in_valid pulses in that window ignored; out_ready=1 -> IDLE next cycle, then in_ready=1.
REQ-034 Assert RST during the 2nd SHIFT cycle of 4'b1111 -> next cycle IDLE, all outputs at reset values, no out_valid; a subsequent 4'b0001 loads correctly.
REQ-035 Back-to-back words 4'b1000 and 4'b0111 with out_ready=1 constantly -> both delivered in order, one idle cycle between them, sr_shift never high more than 4 consecutive cycles.
REQ-036 Build without SHIFT_SEQ_CHECK_EN, load 4'b1100 -> out_valid at E0+4, out_data=4'b1100, out_err=0.
